cpu_thread_sched: RTL and testbench

//  Round-robin hardware-thread scheduler for the stack CPU. It time-slices the

---
 rtl/cpu_thread_sched.sv | 151 +++++++++++++++
 tb/tb_cpu_thread_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_thread_sched.sv
// Round-robin hardware-thread scheduler: time-slices one pipeline between NTHREADS
// contexts by draining, saving the outgoing PC/SP and presenting the incoming one.
module cpu_thread_sched #(
    parameter int unsigned NTHREADS  = 4,
    parameter int unsigned TID_W     = 2,
    parameter int unsigned PC_W      = 11,
    parameter int unsigned SP_W      = 11,
    parameter int unsigned Q_W       = 16,
    parameter int unsigned PC_STRIDE = 256,
    parameter int unsigned SP_STRIDE = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Q_W-1:0]      cfg_quantum,
    input  logic [NTHREADS-1:0] cfg_thread_en,
    input  logic                yield_req,
    input  logic                pipe_empty,
    input  logic [PC_W-1:0]     cur_pc,
    input  logic [SP_W-1:0]     cur_sp,
    output logic                halt_fetch,
    output logic                restore_valid,
    output logic [PC_W-1:0]     restore_pc,
    output logic [SP_W-1:0]     restore_sp,
    output logic [TID_W-1:0]    cur_thread
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SAVE, ST_LOAD} state_t;

    state_t            state_q, state_d;
    logic [TID_W-1:0]  cur_thread_q, cur_thread_d;
    logic [TID_W-1:0]  nxt_q, nxt_d;
    logic [Q_W-1:0]    counter_q, counter_d;
    logic              halt_fetch_q, halt_fetch_d;
    logic              restore_valid_q, restore_valid_d;
    logic [PC_W-1:0]   restore_pc_q, restore_pc_d;
    logic [SP_W-1:0]   restore_sp_q, restore_sp_d;
    logic [PC_W-1:0]   tbl_pc_q [NTHREADS];
    logic [PC_W-1:0]   tbl_pc_d [NTHREADS];
    logic [SP_W-1:0]   tbl_sp_q [NTHREADS];
    logic [SP_W-1:0]   tbl_sp_d [NTHREADS];

    logic              next_found;
    logic [TID_W-1:0]  next_tid;
    logic              quantum_on;
    logic              trigger;

    // Nearest enabled thread after cur_thread; descending scan leaves the closest one.
    always_comb begin
        next_found = 1'b0;
        next_tid   = cur_thread_q;
        for (int unsigned k = NTHREADS - 1; k >= 1; k--) begin
            if (cfg_thread_en[TID_W'(32'(cur_thread_q) + k)]) begin
                next_found = 1'b1;
                next_tid   = TID_W'(32'(cur_thread_q) + k);
            end
        end
    end

    assign quantum_on = (cfg_quantum != '0);
    assign trigger    = yield_req | (quantum_on & (counter_q == '0)) | ~cfg_thread_en[cur_thread_q];

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cur_thread_d = cur_thread_q;
        nxt_d        = nxt_q;
        counter_d    = counter_q;
        restore_pc_d = restore_pc_q;
        restore_sp_d = restore_sp_q;
        tbl_pc_d     = tbl_pc_q;
        tbl_sp_d     = tbl_sp_q;

        case (state_q)
            ST_RUN: begin
                if (quantum_on && counter_q != '0) begin
                    counter_d = counter_q - Q_W'(1);
                end
                if (trigger) begin
                    if (next_found) begin
                        state_d = ST_DRAIN;
                    end else begin
                        counter_d = cfg_quantum;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                tbl_pc_d[cur_thread_q] = cur_pc;
                tbl_sp_d[cur_thread_q] = cur_sp;
                nxt_d = next_found ? next_tid : cur_thread_q;
                // Restoring to ourselves must see the value being saved this cycle.
                if (nxt_d == cur_thread_q) begin
                    restore_pc_d = cur_pc;
                    restore_sp_d = cur_sp;
                end else begin
                    restore_pc_d = tbl_pc_q[nxt_d];
                    restore_sp_d = tbl_sp_q[nxt_d];
                end
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cur_thread_d = nxt_q;
                counter_d    = cfg_quantum;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        halt_fetch_d    = (state_d != ST_RUN);
        restore_valid_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            cur_thread_q    <= '0;
            nxt_q           <= '0;
            counter_q       <= cfg_quantum;
            halt_fetch_q    <= 1'b0;
            restore_valid_q <= 1'b0;
            restore_pc_q    <= '0;
            restore_sp_q    <= '0;
            for (int unsigned i = 0; i < NTHREADS; i++) begin
                tbl_pc_q[i] <= PC_W'(i * PC_STRIDE);
                tbl_sp_q[i] <= SP_W'(i * SP_STRIDE);
            end
        end else begin
            state_q         <= state_d;
            cur_thread_q    <= cur_thread_d;
            nxt_q           <= nxt_d;
            counter_q       <= counter_d;
            halt_fetch_q    <= halt_fetch_d;
            restore_valid_q <= restore_valid_d;
            restore_pc_q    <= restore_pc_d;
            restore_sp_q    <= restore_sp_d;
            tbl_pc_q        <= tbl_pc_d;
            tbl_sp_q        <= tbl_sp_d;
        end
    end

    assign halt_fetch    = halt_fetch_q;
    assign restore_valid = restore_valid_q;
    assign restore_pc    = restore_pc_q;
    assign restore_sp    = restore_sp_q;
    assign cur_thread    = cur_thread_q;

endmodule

// File: tb/tb_cpu_thread_sched.sv
// Bench for cpu_thread_sched: directed scenarios plus random traffic against a
// cycle-level reference model of the scheduling rules.
module tb_cpu_thread_sched;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_quantum;
    logic [3:0]  cfg_thread_en;
    logic        yield_req;
    logic        pipe_empty;
    logic [10:0] cur_pc;
    logic [10:0] cur_sp;
    logic        halt_fetch;
    logic        restore_valid;
    logic [10:0] restore_pc;
    logic [10:0] restore_sp;
    logic [1:0]  cur_thread;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0=run 1=drain 2=save 3=load (as seen after an edge)
    int m_phase = 0, m_cur = 0, m_cnt = 0, m_nxt = 0, m_rpc = 0, m_rsp = 0;
    int m_pc [NT];
    int m_sp [NT];

    always #5 clk = ~clk;

    cpu_thread_sched dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_quantum   (cfg_quantum),
        .cfg_thread_en (cfg_thread_en),
        .yield_req     (yield_req),
        .pipe_empty    (pipe_empty),
        .cur_pc        (cur_pc),
        .cur_sp        (cur_sp),
        .halt_fetch    (halt_fetch),
        .restore_valid (restore_valid),
        .restore_pc    (restore_pc),
        .restore_sp    (restore_sp),
        .cur_thread    (cur_thread)
    );

    function automatic int find_next();
        for (int k = 1; k < NT; k++) begin
            int j;
            j = (m_cur + k) % NT;
            if (cfg_thread_en[j]) return j;
        end
        return -1;
    endfunction

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        int  n;
        bit  trig;
        if (rst) begin
            m_phase = 0; m_cur = 0; m_cnt = int'(cfg_quantum); m_rpc = 0; m_rsp = 0;
            for (int i = 0; i < NT; i++) begin
                m_pc[i] = (i * 256) % 2048;
                m_sp[i] = (i * 512) % 2048;
            end
            return;
        end
        case (m_phase)
            0: begin
                trig = yield_req || (cfg_quantum != 0 && m_cnt == 0) || !cfg_thread_en[m_cur];
                if (cfg_quantum != 0 && m_cnt != 0) m_cnt = m_cnt - 1;
                if (trig) begin
                    n = find_next();
                    if (n >= 0) m_phase = 1;
                    else        m_cnt = int'(cfg_quantum);
                end
            end
            1: if (pipe_empty) m_phase = 2;
            2: begin
                m_pc[m_cur] = int'(cur_pc);
                m_sp[m_cur] = int'(cur_sp);
                n = find_next();
                m_nxt = (n < 0) ? m_cur : n;
                m_rpc = m_pc[m_nxt];
                m_rsp = m_sp[m_nxt];
                m_phase = 3;
            end
            default: begin
                m_cur = m_nxt;
                m_cnt = int'(cfg_quantum);
                m_phase = 0;
            end
        endcase
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic yield_pulse();
        yield_req = 1'b1;
        cycle();
        yield_req = 1'b0;
    endtask

    task automatic wait_rv(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            cycle();
            if (restore_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit got;
        cfg_thread_en = 4'b1111; cfg_quantum = 16'd0; pipe_empty = 1'b1;
        yield_req = 1'b0; cur_pc = 11'h000; cur_sp = 11'h000;
        do_reset();
        n_checks++; if (cur_thread !== 2'd0) begin n_errors++; $display("FAIL reset_cur_thread: got %0d want 0", cur_thread); end
        n_checks++; if (halt_fetch !== 1'b0) begin n_errors++; $display("FAIL reset_halt: got %b want 0", halt_fetch); end
        n_checks++; if (restore_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rv: got %b want 0", restore_valid); end
        n_checks++; if (restore_pc !== 11'd0 || restore_sp !== 11'd0) begin
            n_errors++; $display("FAIL reset_restore: got %0d/%0d want 0/0", restore_pc, restore_sp); end
        cfg_thread_en = 4'b0100;
        wait_rv(10, got);
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL reset_t2_timeout: no restore_valid within 10 cycles"); end
        else if (restore_pc !== 11'd512 || restore_sp !== 11'd1024) begin
            n_errors++; $display("FAIL reset_table2: got %0d/%0d want 512/1024", restore_pc, restore_sp); end
        cycle();
        n_checks++; if (cur_thread !== 2'd2) begin n_errors++; $display("FAIL reset_switch_t2: got %0d want 2", cur_thread); end
    endtask

    task automatic test_quantum();
        int rise;
        bit got;
        cfg_thread_en = 4'b0011; cfg_quantum = 16'd10; pipe_empty = 1'b1;
        cur_pc = 11'h0AA; cur_sp = 11'h055;
        do_reset();
        rise = 0;
        for (int i = 1; i <= 20 && rise == 0; i++) begin
            cycle();
            if (halt_fetch === 1'b1) rise = i;
        end
        n_checks++; if (rise != 11) begin n_errors++; $display("FAIL quantum_rise: got %0d want 11", rise); end
        wait_rv(6, got);
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL quantum_rv_timeout: no restore_valid within 6 cycles"); end
        else if (restore_pc !== 11'd256 || restore_sp !== 11'd512) begin
            n_errors++; $display("FAIL quantum_restore: got %0d/%0d want 256/512", restore_pc, restore_sp); end
        cycle();
        n_checks++; if (cur_thread !== 2'd1) begin n_errors++; $display("FAIL quantum_cur: got %0d want 1", cur_thread); end
        n_checks++; if (restore_valid !== 1'b0 || halt_fetch !== 1'b0) begin
            n_errors++; $display("FAIL quantum_after_load: got rv=%b halt=%b want 0/0", restore_valid, halt_fetch); end
    endtask

    task automatic test_yield_drain();
        bit got;
        bit bad;
        cfg_quantum = 16'd0;
        cur_pc = 11'h123; cur_sp = 11'h055; pipe_empty = 1'b0;
        yield_pulse();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (halt_fetch !== 1'b1 || restore_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_errors++; $display("FAIL drain_hold: got halt=%b rv=%b want 1/0", halt_fetch, restore_valid); end
        pipe_empty = 1'b1;
        cycle();
        n_checks++; if (halt_fetch !== 1'b1 || restore_valid !== 1'b0) begin
            n_errors++; $display("FAIL drain_save: got halt=%b rv=%b want 1/0", halt_fetch, restore_valid); end
        cycle();
        n_checks++; if (restore_valid !== 1'b1 || restore_pc !== 11'h0AA || restore_sp !== 11'h055) begin
            n_errors++; $display("FAIL drain_load: got rv=%b pc=%h sp=%h want 1/0aa/055", restore_valid, restore_pc, restore_sp); end
        cycle();
        n_checks++; if (cur_thread !== 2'd0) begin n_errors++; $display("FAIL drain_cur: got %0d want 0", cur_thread); end
        cur_pc = 11'h321; cur_sp = 11'h111;
        yield_pulse();
        wait_rv(6, got);
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL drain_back_timeout: no restore_valid within 6 cycles"); end
        else if (restore_pc !== 11'h123 || restore_sp !== 11'h055) begin
            n_errors++; $display("FAIL drain_back_restore: got %h/%h want 123/055", restore_pc, restore_sp); end
        cycle();
    endtask

    task automatic test_single_thread();
        bit bad;
        cfg_thread_en = 4'b0001; cfg_quantum = 16'd3; pipe_empty = 1'b1;
        do_reset();
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            yield_req = ($urandom_range(0, 3) == 0);
            cycle();
            if (halt_fetch !== 1'b0 || restore_valid !== 1'b0) bad = 1'b1;
        end
        yield_req = 1'b0;
        n_checks++; if (bad) begin n_errors++; $display("FAIL single_no_switch: halt or restore_valid asserted, want never"); end
        n_checks++; if (cur_thread !== 2'd0) begin n_errors++; $display("FAIL single_cur: got %0d want 0", cur_thread); end
    endtask

    task automatic test_rotation();
        int exp_seq [3];
        bit got;
        exp_seq[0] = 1; exp_seq[1] = 3; exp_seq[2] = 0;
        cfg_thread_en = 4'b1011; cfg_quantum = 16'd4; pipe_empty = 1'b1;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            wait_rv(30, got);
            cycle();
            n_checks++;
            if (!got || cur_thread !== 2'(exp_seq[s])) begin
                n_errors++; $display("FAIL rotation_step%0d: got %0d (rv seen=%b) want %0d", s, cur_thread, got, exp_seq[s]); end
        end
        cfg_quantum = 16'd0;
        cycle();
        cycle();
        cfg_thread_en = 4'b1010;
        cycle();
        n_checks++; if (halt_fetch !== 1'b1) begin n_errors++; $display("FAIL rotation_disable_cur: got halt=%b want 1", halt_fetch); end
        wait_rv(6, got);
        cycle();
        n_checks++; if (!got || cur_thread !== 2'd1) begin
            n_errors++; $display("FAIL rotation_after_disable: got %0d want 1", cur_thread); end
    endtask

    task automatic test_reset_mid_drain();
        bit got;
        cfg_thread_en = 4'b0011; cfg_quantum = 16'd0; pipe_empty = 1'b1;
        do_reset();
        cur_pc = 11'h044; cur_sp = 11'h144;
        yield_pulse(); wait_rv(6, got); cycle();
        cur_pc = 11'h099; cur_sp = 11'h199;
        yield_pulse(); wait_rv(6, got); cycle();
        pipe_empty = 1'b0;
        yield_pulse();
        cycle();
        n_checks++; if (halt_fetch !== 1'b1) begin n_errors++; $display("FAIL rstdrain_in_drain: got halt=%b want 1", halt_fetch); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++; if (halt_fetch !== 1'b0 || cur_thread !== 2'd0 || restore_valid !== 1'b0) begin
            n_errors++; $display("FAIL rstdrain_state: got halt=%b cur=%0d rv=%b want 0/0/0", halt_fetch, cur_thread, restore_valid); end
        pipe_empty = 1'b1;
        yield_pulse();
        wait_rv(6, got);
        n_checks++;
        if (!got || restore_pc !== 11'd256 || restore_sp !== 11'd512) begin
            n_errors++; $display("FAIL rstdrain_table: got %0d/%0d (rv seen=%b) want 256/512", restore_pc, restore_sp, got); end
        cycle();
    endtask

    task automatic test_random();
        cfg_thread_en = 4'($urandom_range(1, 15)); cfg_quantum = 16'($urandom_range(0, 6));
        pipe_empty = 1'b1; yield_req = 1'b0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            yield_req  = ($urandom_range(0, 7) == 0);
            pipe_empty = ($urandom_range(0, 2) != 0);
            cur_pc     = 11'($urandom);
            cur_sp     = 11'($urandom);
            if ($urandom_range(0, 39) == 0) cfg_thread_en = 4'($urandom);
            if ($urandom_range(0, 59) == 0) cfg_quantum = 16'($urandom_range(0, 8));
            cycle();
            n_checks++; if (halt_fetch !== (m_phase != 0)) begin
                n_errors++; $display("FAIL rand_halt cyc%0d: got %b want %b", i, halt_fetch, (m_phase != 0)); end
            n_checks++; if (restore_valid !== (m_phase == 3)) begin
                n_errors++; $display("FAIL rand_rv cyc%0d: got %b want %b", i, restore_valid, (m_phase == 3)); end
            n_checks++; if (restore_pc !== 11'(m_rpc) || restore_sp !== 11'(m_rsp)) begin
                n_errors++; $display("FAIL rand_restore cyc%0d: got %h/%h want %h/%h", i, restore_pc, restore_sp, m_rpc, m_rsp); end
            n_checks++; if (cur_thread !== 2'(m_cur)) begin
                n_errors++; $display("FAIL rand_cur cyc%0d: got %0d want %0d", i, cur_thread, m_cur); end
        end
        yield_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_quantum = 16'd0; cfg_thread_en = 4'b1111; yield_req = 1'b0;
        pipe_empty = 1'b1; cur_pc = 11'h000; cur_sp = 11'h000;
        for (int i = 0; i < NT; i++) begin m_pc[i] = 0; m_sp[i] = 0; end
        test_reset();
        test_quantum();
        test_yield_drain();
        test_single_thread();
        test_rotation();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
